// File: rtl/count_seq_monitor.sv
// Sequence checker for a free-running up/down counter bus.
// Define COUNT_SEQ_MONITOR_RESYNC_EN to tolerate observed counter resets while locked.
module count_seq_monitor #(
  parameter int unsigned WIDTH = 5,
  parameter bit DOWN = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             seq_error,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0] last_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

`ifdef COUNT_SEQ_MONITOR_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             crossing;
  logic             resync_hit;

  logic [WIDTH-1:0] last_d;
  logic [CNT_W-1:0] err_d;
  logic [CNT_W-1:0] wrap_d;
  logic             seq_d;
  logic             wrp_d;

  assign exp_val = DOWN ? (last_value - ONE) : (last_value + ONE);
  assign match = (count_in == exp_val);

  assign crossing = DOWN
    ? (last_value == '0 && count_in == MAXV)
    : (last_value == MAXV && count_in == '0);

  // A jump to the counter's reset value is its own reset, not a fault.
  assign resync_hit = RESYNC && (count_in == RESET_VAL) && !match;

  assign locked = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    last_d  = last_value;
    err_d   = err_count;
    wrap_d  = wrap_count;
    seq_d   = 1'b0;
    wrp_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      err_d   = '0;
      wrap_d  = '0;
    end else if (sample_en) begin
      last_d = count_in;
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (match) state_d = LOCKED;
        end
        LOCKED: begin
          unique case (1'b1)
            match: begin
              if (crossing) begin
                wrp_d = 1'b1;
                if (wrap_count != CMAX) wrap_d = wrap_count + CONE;
              end
            end
            resync_hit: begin
              state_d = LOCKED;
            end
            default: begin
              seq_d   = 1'b1;
              state_d = SYNC;
              if (err_count != CMAX) err_d = err_count + CONE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_value <= '0;
      err_count  <= '0;
      wrap_count <= '0;
      seq_error  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_value <= last_d;
      err_count  <= err_d;
      wrap_count <= wrap_d;
      seq_error  <= seq_d;
      wrap_pulse <= wrp_d;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor (WIDTH=5, DOWN=1, CNT_W=4).
// Expected outputs are queued per driven cycle and compared after each edge.
module tb_count_seq_monitor;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_en;
  logic [4:0]    count_in;
  logic          clear;
  logic          locked;
  logic          seq_error;
  logic          wrap_pulse;
  logic [CW-1:0] err_count;
  logic [CW-1:0] wrap_count;
  logic [4:0]    last_value;

  count_seq_monitor #(
    .WIDTH(5), .DOWN(1'b1), .RESET_VAL(5'd31), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
    .count_in(count_in), .clear(clear), .locked(locked),
    .seq_error(seq_error), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count),
    .last_value(last_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          lk;
    logic          se;
    logic          wp;
    logic [CW-1:0] ec;
    logic [CW-1:0] wc;
    logic [4:0]    lv;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  int       m_state;
  logic [4:0] m_last;
  int       m_err;
  int       m_wrap;
  bit       m_resync;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last = 5'd0;
    m_err = 0;
    m_wrap = 0;
  endtask

  task automatic model_step(input logic en, input logic [4:0] v,
                            input logic clr);
    exp_t e;
    logic [4:0] ev;
    ev = m_last - 5'd1;
    e.se = 1'b0;
    e.wp = 1'b0;
    if (clr) begin
      m_state = 0;
      m_err = 0;
      m_wrap = 0;
    end else if (en) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (v == ev) m_state = 2;
      end else begin
        if (v == ev) begin
          if (m_last == 5'd0 && v == 5'd31) begin
            e.wp = 1'b1;
            if (m_wrap < (1 << CW) - 1) m_wrap++;
          end
        end else if (!(m_resync && v == 5'd31)) begin
          e.se = 1'b1;
          if (m_err < (1 << CW) - 1) m_err++;
          m_state = 1;
        end
      end
      m_last = v;
    end
    e.lk = (m_state == 2);
    e.ec = CW'(m_err);
    e.wc = CW'(m_wrap);
    e.lv = m_last;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("locked", locked, e.lk);
    check("seq_error", seq_error, e.se);
    check("wrap_pulse", wrap_pulse, e.wp);
    check("err_count", err_count, e.ec);
    check("wrap_count", wrap_count, e.wc);
    check("last_value", last_value, e.lv);
  endtask

  task automatic step(input logic en, input logic [4:0] v,
                      input logic clr);
    sample_en = en;
    count_in = v;
    clear = clr;
    model_step(en, v, clr);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_seq"}, seq_error, 0);
    check({tag, "_wrap_p"}, wrap_pulse, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_wrap_c"}, wrap_count, 0);
    check({tag, "_last"}, last_value, 0);
  endtask

  initial begin
`ifdef COUNT_SEQ_MONITOR_RESYNC_EN
    m_resync = 1'b1;
`else
    m_resync = 1'b0;
`endif
    model_reset();
    reset_n = 1'b0;
    sample_en = 1'b0;
    count_in = '0;
    clear = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // lock from reset value, then walk down through the wrap
    for (int v = 31; v >= 0; v--) step(1'b1, 5'(v), 1'b0);
    for (int v = 31; v >= 20; v--) step(1'b1, 5'(v), 1'b0);

    // skip: error, then relock
    step(1'b1, 5'd17, 1'b0);
    for (int v = 16; v >= 10; v--) step(1'b1, 5'(v), 1'b0);

    // observed counter reset
    step(1'b1, 5'd31, 1'b0);
    step(1'b1, 5'd30, 1'b0);
    step(1'b1, 5'd29, 1'b0);
    step(1'b1, 5'd28, 1'b0);

    // idle gap then expected value, then a stall
    for (int i = 0; i < 7; i++) step(1'b0, 5'(i * 3), 1'b0);
    step(1'b1, 5'd27, 1'b0);
    step(1'b1, 5'd27, 1'b0);

    // drive errors well past saturation
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'd12, 1'b0);
      step(1'b1, 5'd11, 1'b0);
      step(1'b1, 5'd5, 1'b0);
    end

    // clear with a simultaneous sample
    step(1'b1, 5'd4, 1'b1);
    step(1'b1, 5'd3, 1'b0);
    step(1'b1, 5'd2, 1'b0);

    // mixed random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] v;
      logic en;
      logic clr;
      en = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 9) ? m_last - 5'd1
                                      : 5'($urandom_range(0, 31));
      step(en, v, clr);
    end

    // async reset mid-run
    for (int v = 20; v >= 15; v--) step(1'b1, 5'(v), 1'b0);
    #2;
    reset_n = 1'b0;
    sample_en = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset_n = 1'b1;
    step(1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd8, 1'b0);
    step(1'b1, 5'd7, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
